// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory bus arbiter.
package mem_bus_arbiter_pkg;

  localparam int ARB_LEN_W   = 4;
  localparam int MBUS_ADDR_W = 64;
  localparam int MBUS_DATA_W = 64;
  localparam int MBUS_STRB_W = MBUS_DATA_W / 8;

  // Owner encoding used by the last_owner register and the winner select.
  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                   valid;
    logic [MBUS_ADDR_W-1:0] addr;
    logic                   write;
    logic [MBUS_STRB_W-1:0] strobe;
    logic [ARB_LEN_W-1:0]   len;
    logic [MBUS_DATA_W-1:0] wdata;
  } mbus_req_t;

  typedef struct packed {
    logic                   ready;
    logic                   last;
    logic [MBUS_DATA_W-1:0] data;
  } mbus_resp_t;

endpackage

// File: rtl/mem_bus_arbiter_pick.sv
// Combinational winner select between the fetch (I) and data (D) requesters.
module mem_arb_pick
  import mem_bus_arbiter_pkg::*;
#(
  parameter bit RR_MODE = 1'b0
) (
  input  logic i_valid,
  input  logic d_valid,
  input  logic last_owner,
  output logic pick_d,
  output logic pick_any
);

  // Contention goes to D in fixed mode, or to the port not served last in round-robin.
  always_comb begin
    pick_any = i_valid | d_valid;
    if (i_valid && d_valid) begin
      pick_d = RR_MODE ? (last_owner == OWNER_I) : 1'b1;
    end else begin
      pick_d = d_valid;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the fetch port (I) and the data port (D).
// Handshake: a granted owner keeps x_valid and its request fields stable until
// the beat on which m_ready and m_last are both high; every cycle with m_ready
// high is one beat, routed only to the owner. One IDLE cycle separates owners.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter bit RR_MODE = 1'b0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 i_valid,
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic [ARB_LEN_W-1:0] i_len,
  output logic                 i_ready,
  output logic                 i_last,
  output logic [DATA_W-1:0]    i_data,
  input  logic                 d_valid,
  input  logic [ADDR_W-1:0]    d_addr,
  input  logic                 d_write,
  input  logic [DATA_W/8-1:0]  d_strobe,
  input  logic [ARB_LEN_W-1:0] d_len,
  input  logic [DATA_W-1:0]    d_wdata,
  output logic                 d_ready,
  output logic                 d_last,
  output logic [DATA_W-1:0]    d_data,
  output logic                 m_valid,
  output logic [ADDR_W-1:0]    m_addr,
  output logic                 m_write,
  output logic [DATA_W/8-1:0]  m_strobe,
  output logic [ARB_LEN_W-1:0] m_len,
  output logic [DATA_W-1:0]    m_wdata,
  input  logic                 m_ready,
  input  logic                 m_last,
  input  logic [DATA_W-1:0]    m_data,
  output logic                 proto_err,
  output logic [1:0]           arb_state
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_OWN_I = OWN_I;
  localparam logic [1:0] S_OWN_D = OWN_D;

  logic [1:0] state;
  logic       last_owner;
  logic       pick_d;
  logic       pick_any;
  logic       own_i;
  logic       own_d;

  assign own_i     = (state == S_OWN_I);
  assign own_d     = (state == S_OWN_D);
  assign arb_state = state;

  mem_arb_pick #(
    .RR_MODE (RR_MODE)
  ) u_pick (
    .i_valid    (i_valid),
    .d_valid    (d_valid),
    .last_owner (last_owner),
    .pick_d     (pick_d),
    .pick_any   (pick_any)
  );

  // Owner FSM: grant from IDLE, hold until the final beat; flag stray beats in IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      last_owner <= OWNER_I;
      proto_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (m_ready) begin
            proto_err <= 1'b1;
          end
          if (pick_any) begin
            state      <= pick_d ? S_OWN_D : S_OWN_I;
            last_owner <= pick_d;
          end
        end
        S_OWN_I, S_OWN_D: begin
          if (m_ready && m_last) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Request mux: forward the owner's fields; I never writes, so its write side is zero.
  always_comb begin
    m_valid  = own_i | own_d;
    m_addr   = '0;
    m_write  = 1'b0;
    m_strobe = '0;
    m_len    = '0;
    m_wdata  = '0;
    if (own_i) begin
      m_addr = i_addr;
      m_len  = i_len;
    end else if (own_d) begin
      m_addr   = d_addr;
      m_write  = d_write;
      m_strobe = d_strobe;
      m_len    = d_len;
      m_wdata  = d_wdata;
    end
  end

  // Response demux: only the owner sees beats; the other port reads all zeros.
  assign i_ready = own_i & m_ready;
  assign i_last  = own_i & m_last;
  assign i_data  = own_i ? m_data : '0;
  assign d_ready = own_d & m_ready;
  assign d_last  = own_d & m_last;
  assign d_data  = own_d ? m_data : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a fixed-priority and a round-robin instance share all inputs.
module tb_mem_bus_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int SW = DW / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // ---------------- shared inputs ----------------
  logic          i_valid;
  logic [AW-1:0] i_addr;
  logic [3:0]    i_len;
  logic          d_valid;
  logic [AW-1:0] d_addr;
  logic          d_write;
  logic [SW-1:0] d_strobe;
  logic [3:0]    d_len;
  logic [DW-1:0] d_wdata;
  logic          m_ready;
  logic          m_last;
  logic [DW-1:0] m_data;

  // ---------------- per-instance outputs (0: fixed, 1: round-robin) ----------------
  logic [1:0]         i_ready_o, i_last_o, d_ready_o, d_last_o, m_valid_o, m_write_o, perr_o;
  logic [1:0][DW-1:0] i_data_o, d_data_o, m_wdata_o;
  logic [1:0][AW-1:0] m_addr_o;
  logic [1:0][SW-1:0] m_strobe_o;
  logic [1:0][3:0]    m_len_o;
  logic [1:0][1:0]    st_o;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_MODE(1'b0)) dut0 (
    .clk(clk), .resetn(resetn),
    .i_valid(i_valid), .i_addr(i_addr), .i_len(i_len),
    .i_ready(i_ready_o[0]), .i_last(i_last_o[0]), .i_data(i_data_o[0]),
    .d_valid(d_valid), .d_addr(d_addr), .d_write(d_write), .d_strobe(d_strobe),
    .d_len(d_len), .d_wdata(d_wdata),
    .d_ready(d_ready_o[0]), .d_last(d_last_o[0]), .d_data(d_data_o[0]),
    .m_valid(m_valid_o[0]), .m_addr(m_addr_o[0]), .m_write(m_write_o[0]),
    .m_strobe(m_strobe_o[0]), .m_len(m_len_o[0]), .m_wdata(m_wdata_o[0]),
    .m_ready(m_ready), .m_last(m_last), .m_data(m_data),
    .proto_err(perr_o[0]), .arb_state(st_o[0])
  );

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_MODE(1'b1)) dut1 (
    .clk(clk), .resetn(resetn),
    .i_valid(i_valid), .i_addr(i_addr), .i_len(i_len),
    .i_ready(i_ready_o[1]), .i_last(i_last_o[1]), .i_data(i_data_o[1]),
    .d_valid(d_valid), .d_addr(d_addr), .d_write(d_write), .d_strobe(d_strobe),
    .d_len(d_len), .d_wdata(d_wdata),
    .d_ready(d_ready_o[1]), .d_last(d_last_o[1]), .d_data(d_data_o[1]),
    .m_valid(m_valid_o[1]), .m_addr(m_addr_o[1]), .m_write(m_write_o[1]),
    .m_strobe(m_strobe_o[1]), .m_len(m_len_o[1]), .m_wdata(m_wdata_o[1]),
    .m_ready(m_ready), .m_last(m_last), .m_data(m_data),
    .proto_err(perr_o[1]), .arb_state(st_o[1])
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int viol     = 0;

  task automatic check(input string name, input int k, input logic [511:0] got,
                       input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, k, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Owner per instance: 0 = nobody, 1 = I, 2 = D. last_srv is the port served most recently.
  int own[2];
  int last_srv[2];
  bit pe_m[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      own[k]      = 0;
      last_srv[k] = 1;
      pe_m[k]     = 1'b0;
    end
  endtask

  task automatic model_step(input int k);
    int w;
    if (!resetn) begin
      own[k] = 0; last_srv[k] = 1; pe_m[k] = 1'b0;
    end else if (own[k] == 0) begin
      if (m_ready) pe_m[k] = 1'b1;
      if (i_valid || d_valid) begin
        if (i_valid && d_valid) w = (k == 0) ? 2 : ((last_srv[k] == 2) ? 1 : 2);
        else                    w = d_valid ? 2 : 1;
        own[k]      = w;
        last_srv[k] = w;
      end
    end else if (m_ready && m_last) begin
      own[k] = 0;
    end
  endtask

  function automatic logic [511:0] pack_out(
    input logic mv, input logic [AW-1:0] a, input logic w, input logic [SW-1:0] s,
    input logic [3:0] l, input logic [DW-1:0] wd, input logic ir, input logic il,
    input logic [DW-1:0] idt, input logic dr, input logic dl, input logic [DW-1:0] ddt,
    input logic pe);
    return 512'({mv, a, w, s, l, wd, ir, il, idt, dr, dl, ddt, pe});
  endfunction

  function automatic logic [511:0] model_out(input int k);
    logic oi, od;
    oi = (own[k] == 1);
    od = (own[k] == 2);
    return pack_out(oi | od, oi ? i_addr : (od ? d_addr : '0), od & d_write,
                    od ? d_strobe : '0, oi ? i_len : (od ? d_len : '0), od ? d_wdata : '0,
                    oi & m_ready, oi & m_last, oi ? m_data : '0,
                    od & m_ready, od & m_last, od ? m_data : '0, pe_m[k]);
  endfunction

  function automatic logic [511:0] actual_out(input int k);
    return pack_out(m_valid_o[k], m_addr_o[k], m_write_o[k], m_strobe_o[k], m_len_o[k],
                    m_wdata_o[k], i_ready_o[k], i_last_o[k], i_data_o[k],
                    d_ready_o[k], d_last_o[k], d_data_o[k], perr_o[k]);
  endfunction

  // Called at the falling edge: compare both instances, note owner drops, advance model.
  task automatic sample_and_step();
    for (int k = 0; k < 2; k++) check("model_cycle", k, actual_out(k), model_out(k));
    if ((own[0] == 1 && !i_valid) || (own[0] == 2 && !d_valid)) begin
      viol++;
      $display("note: owner request dropped while granted at %0t", $time);
    end
    for (int k = 0; k < 2; k++) model_step(k);
  endtask

  task automatic cycle();
    @(negedge clk);
    sample_and_step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  // ins = {i_valid, d_valid, m_ready, m_last}; ex = {m_valid, m_write, i_ready, i_last,
  // d_ready, d_last, proto_err}; eid/edd = low byte of i_data/d_data.
  typedef struct packed {
    logic [3:0] ins;
    logic [7:0] md;
    logic [6:0] ex;
    logic [7:0] eid;
    logic [7:0] edd;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] ins, input logic [7:0] md,
                              input logic [6:0] ex, input logic [7:0] eid,
                              input logic [7:0] edd);
    vec_t v;
    v.ins = ins; v.md = md; v.ex = ex; v.eid = eid; v.edd = edd;
    return v;
  endfunction

  vec_t tbl[15];
  int   exp_q[$];
  int   g_own0[$];
  int   g_own1[$];
  int   g_t1[$];

  initial begin
    logic [1:0] prev_mv;
    int         own_cnt;
    int         e;

    // D store len0 vs I, then I burst of 4, then stray beat in IDLE and one more D txn.
    tbl[0]  = mk(4'b1100, 8'h00, 7'b0000000, 8'h00, 8'h00);
    tbl[1]  = mk(4'b1100, 8'h00, 7'b1100000, 8'h00, 8'h00);
    tbl[2]  = mk(4'b1111, 8'hAA, 7'b1100110, 8'h00, 8'hAA);
    tbl[3]  = mk(4'b1000, 8'h00, 7'b0000000, 8'h00, 8'h00);
    tbl[4]  = mk(4'b1000, 8'h00, 7'b1000000, 8'h00, 8'h00);
    tbl[5]  = mk(4'b1010, 8'h11, 7'b1010000, 8'h11, 8'h00);
    tbl[6]  = mk(4'b1010, 8'h22, 7'b1010000, 8'h22, 8'h00);
    tbl[7]  = mk(4'b1010, 8'h33, 7'b1010000, 8'h33, 8'h00);
    tbl[8]  = mk(4'b1011, 8'h44, 7'b1011000, 8'h44, 8'h00);
    tbl[9]  = mk(4'b0000, 8'h00, 7'b0000000, 8'h00, 8'h00);
    tbl[10] = mk(4'b0010, 8'h55, 7'b0000000, 8'h00, 8'h00);
    tbl[11] = mk(4'b0000, 8'h00, 7'b0000001, 8'h00, 8'h00);
    tbl[12] = mk(4'b0100, 8'h00, 7'b0000001, 8'h00, 8'h00);
    tbl[13] = mk(4'b0111, 8'h66, 7'b1100111, 8'h00, 8'h66);
    tbl[14] = mk(4'b0000, 8'h00, 7'b0000001, 8'h00, 8'h00);

    resetn   = 1'b0;
    i_valid  = 1'b0; i_addr = 64'h8000_0000; i_len = 4'd3;
    d_valid  = 1'b0; d_addr = 64'h8000_1000; d_write = 1'b1; d_strobe = 8'hFF;
    d_len    = 4'd0; d_wdata = 64'hDEAD_BEEF_0000_0001;
    m_ready  = 1'b0; m_last = 1'b0; m_data = '0;
    model_reset();

    // Reset state.
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("reset_outputs", k, actual_out(k), 512'd0);
      check("reset_state", k, 512'(st_o[k]), 512'd0);
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Table-driven directed sequence.
    for (int r = 0; r < 15; r++) begin
      {i_valid, d_valid, m_ready, m_last} = tbl[r].ins;
      m_data = {56'd0, tbl[r].md};
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        check($sformatf("table_row%0d", r), k,
              512'({m_valid_o[k], m_write_o[k], i_ready_o[k], i_last_o[k], d_ready_o[k],
                    d_last_o[k], perr_o[k], i_data_o[k], d_data_o[k]}),
              512'({tbl[r].ex, 56'd0, tbl[r].eid, 56'd0, tbl[r].edd}));
        if (tbl[r].ex[6]) check($sformatf("table_addr%0d", r), k, 512'(m_addr_o[k]),
                                512'(tbl[r].ex[5] ? 64'h8000_1000 : 64'h8000_0000));
      end
      sample_and_step();
      @(posedge clk);
      #1;
    end

    // Reset in the middle of a 4-beat D burst, then I is granted right after release.
    d_len = 4'd3; i_len = 4'd0; d_valid = 1'b1;
    cycle();
    m_ready = 1'b1; m_last = 1'b0; m_data = 64'h0101;
    cycle();
    m_data = 64'h0202;
    #1;
    check("beat2_live", 0, 512'({d_ready_o, m_valid_o, perr_o}), 512'(6'b111111));
    #1;
    resetn = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++)
      check("reset_mid_burst", k, 512'({m_valid_o[k], d_ready_o[k], perr_o[k], st_o[k]}),
            512'd0);
    m_ready = 1'b0; d_valid = 1'b0; i_valid = 1'b1;
    @(negedge clk);
    sample_and_step();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cycle();
    for (int k = 0; k < 2; k++)
      check("grant_after_reset", k, 512'({m_valid_o[k], m_write_o[k], m_addr_o[k]}),
            512'({1'b1, 1'b0, 64'h8000_0000}));
    m_ready = 1'b1; m_last = 1'b1; m_data = 64'h0303;
    cycle();
    i_valid = 1'b0; m_ready = 1'b0; m_last = 1'b0;
    cycle();

    // Both ports continuously valid, len 0, memory answers one cycle after the grant.
    i_len = 4'd0; d_len = 4'd0; i_valid = 1'b1; d_valid = 1'b1;
    prev_mv = m_valid_o;
    own_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (c >= 24 && m_valid_o == 2'b00) break;
      for (int k = 0; k < 2; k++) begin
        if (m_valid_o[k] && !prev_mv[k]) begin
          if (k == 0) g_own0.push_back(m_write_o[k] ? 2 : 1);
          else begin
            g_own1.push_back(m_write_o[k] ? 2 : 1);
            g_t1.push_back(c);
          end
        end
      end
      prev_mv = m_valid_o;
      if (m_valid_o[1]) begin
        m_ready = (own_cnt == 1);
        own_cnt++;
      end else begin
        m_ready = 1'b0;
        own_cnt = 0;
      end
      m_last = m_ready;
      m_data = {$urandom, $urandom};
      cycle();
    end
    i_valid = 1'b0; d_valid = 1'b0; m_ready = 1'b0; m_last = 1'b0;
    cycle();

    check("rr_grant_count", 1, 512'(g_own1.size() >= 4), 512'd1);
    check("fp_grant_count", 0, 512'(g_own0.size() >= 4), 512'd1);
    exp_q = '{2, 1, 2, 1};
    for (int j = 0; j < 4 && j < g_own1.size(); j++) begin
      e = exp_q.pop_front();
      check($sformatf("rr_order%0d", j), 1, 512'(g_own1[j]), 512'(e));
      check($sformatf("fp_order%0d", j), 0, 512'(g_own0[j]), 512'd2);
    end
    if (g_t1.size() >= 4) begin
      check("rr_period_d", 1, 512'(g_t1[2] - g_t1[0]), 512'd6);
      check("rr_period_i", 1, 512'(g_t1[3] - g_t1[1]), 512'd6);
    end

    // Randomised traffic; an owner's request is held until its final beat.
    for (int c = 0; c < 1500; c++) begin
      if (own[0] != 1 && own[1] != 1) begin
        i_valid = ($urandom_range(0, 2) != 0);
        i_addr  = {$urandom, $urandom};
        i_len   = 4'($urandom_range(0, 15));
      end
      if (own[0] != 2 && own[1] != 2) begin
        d_valid  = ($urandom_range(0, 2) != 0);
        d_addr   = {$urandom, $urandom};
        d_write  = 1'($urandom_range(0, 1));
        d_strobe = 8'($urandom_range(0, 255));
        d_len    = 4'($urandom_range(0, 15));
      end
      d_wdata = {$urandom, $urandom};
      if (own[0] == 0 && own[1] == 0) m_ready = ($urandom_range(0, 19) == 0);
      else                            m_ready = ($urandom_range(0, 1) == 1);
      m_last = ($urandom_range(0, 2) == 0);
      m_data = {$urandom, $urandom};
      cycle();
    end
    i_valid = 1'b0; d_valid = 1'b0; m_ready = 1'b0; m_last = 1'b0;
    for (int c = 0; c < 40 && (own[0] != 0 || own[1] != 0); c++) begin
      m_ready = 1'b1; m_last = 1'b1;
      if (own[0] == 1 || own[1] == 1) i_valid = 1'b1;
      if (own[0] == 2 || own[1] == 2) d_valid = 1'b1;
      cycle();
      i_valid = 1'b0; d_valid = 1'b0;
    end
    m_ready = 1'b0; m_last = 1'b0;
    cycle();

    // D drops its request mid-transaction: the grant holds until the final beat.
    viol = 0;
    d_addr = 64'h8000_2000; d_write = 1'b1; d_len = 4'd1; d_valid = 1'b1;
    cycle();
    d_valid = 1'b0;
    cycle();
    check("held_after_drop", 0, 512'({m_valid_o, m_addr_o[0], m_addr_o[1]}),
          512'({2'b11, 64'h8000_2000, 64'h8000_2000}));
    m_ready = 1'b1; m_last = 1'b1;
    cycle();
    m_ready = 1'b0; m_last = 1'b0;
    cycle();
    check("release_after_last", 0, 512'(m_valid_o), 512'd0);
    check("owner_drop_flagged", 0, 512'(viol), 512'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
